// File: rtl/hmr_pkg.sv
// Shared types and constants for the HMR mode-change sequencer.
package hmr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StFlush,
    StDrain,
    StSwitch,
    StResume
  } hmr_mode_state_e;

  localparam logic HMR_MODE_INDEP = 1'b0;
  localparam logic HMR_MODE_DMR   = 1'b1;

  // In DMR mode cache1 shadows cache0, so only cache0 holds state worth flushing.
  function automatic logic [1:0] active_caches(input logic dmr);
    return dmr ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/hmr_timeout_cnt.sv
// Wait-state watchdog: counts cycles while enabled, flags the last allowed cycle.
module hmr_timeout_cnt #(
  parameter int unsigned MaxCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(MaxCycles);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MaxCycles - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hmr_mode_ctrl.sv
// Sequences safe independent/DMR mode switches and counts DMR mismatches.
// Optional HMR_MODE_CTRL_AUTO_FALLBACK_EN: a counted failure drops back to independent mode.
module hmr_mode_ctrl
  import hmr_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned FailCntWidth  = 8,
  parameter logic        ResetDmr      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mode_req_valid_i,
  input  logic                    mode_req_dmr_i,
  output logic                    mode_req_ready_o,
  output logic                    mode_done_o,
  output logic                    mode_err_o,
  output logic                    dmr_mode_active_o,
  output logic [1:0]              core_halt_o,
  input  logic [1:0]              core_halted_i,
  output logic [1:0]              dcache_flush_o,
  input  logic [1:0]              dcache_flush_ack_i,
  input  logic [1:0]              dcache_wbuffer_empty_i,
  input  logic                    dmr_failure_i,
  input  logic                    fail_cnt_clr_i,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic                    fail_irq_o
);

  hmr_mode_state_e   state_q, state_d;
  logic              mode_q, mode_d;
  logic [1:0]        flush_q, flush_d;
  logic [1:0]        acked_q, acked_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_d;
  logic              irq_q, irq_d;

  logic       tmo_clr, tmo_en, tmo_expired;
  logic       fail_counted, fallback_start;
  logic [1:0] active, acked_now;

  // SWITCH is excluded because the lockstep comparison is not meaningful while the mode flips.
  assign fail_counted = dmr_failure_i && (mode_q == HMR_MODE_DMR) && (state_q != StSwitch);

`ifdef HMR_MODE_CTRL_AUTO_FALLBACK_EN
  logic pend_q, pend_d;

  assign fallback_start = (state_q == StIdle) && (mode_q == HMR_MODE_DMR) &&
                          (fail_counted || pend_q);

  always_comb begin
    pend_d = pend_q;
    if (state_q == StIdle) begin
      pend_d = 1'b0;
    end else if (fail_counted) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign fallback_start = 1'b0;
`endif

  assign active    = active_caches(mode_q);
  assign acked_now = acked_q | (dcache_flush_ack_i & flush_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    flush_d = flush_q;
    acked_d = acked_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fallback_start) begin
          state_d = StHalt;
        end else if (mode_req_valid_i) begin
          if (mode_req_dmr_i == mode_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (core_halted_i == 2'b11) begin
          state_d = StFlush;
          flush_d = active;
          acked_d = '0;
        end else if (tmo_expired) begin
          state_d = StResume;
          err_d   = 1'b1;
        end
      end
      StFlush: begin
        acked_d = acked_now;
        flush_d = flush_q & ~dcache_flush_ack_i;
        if ((acked_now & active) == active) begin
          state_d = StDrain;
        end else if (tmo_expired) begin
          state_d = StResume;
          flush_d = '0;
          err_d   = 1'b1;
        end
      end
      StDrain: begin
        if ((dcache_wbuffer_empty_i & active) == active) begin
          state_d = StSwitch;
        end else if (tmo_expired) begin
          state_d = StResume;
          err_d   = 1'b1;
        end
      end
      StSwitch: begin
        mode_d  = ~mode_q;
        done_d  = 1'b1;
        state_d = StResume;
      end
      StResume: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign tmo_en  = (state_q == StHalt) || (state_q == StFlush) || (state_q == StDrain);
  assign tmo_clr = (state_d != state_q);

  hmr_timeout_cnt #(
    .MaxCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    irq_d      = irq_q;
    if (fail_cnt_clr_i) begin
      fail_cnt_d = {{(FailCntWidth-1){1'b0}}, fail_counted};
      irq_d      = fail_counted;
    end else if (fail_counted) begin
      if (fail_cnt_q != '1) begin
        fail_cnt_d = fail_cnt_q + FailCntWidth'(1);
      end
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= ResetDmr;
      flush_q    <= '0;
      acked_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fail_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      flush_q    <= flush_d;
      acked_q    <= acked_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fail_cnt_q <= fail_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign mode_req_ready_o  = (state_q == StIdle) && !fallback_start;
  assign mode_done_o       = done_q;
  assign mode_err_o        = err_q;
  assign dmr_mode_active_o = mode_q;
  assign core_halt_o       = ((state_q == StHalt) || (state_q == StFlush) ||
                              (state_q == StDrain) || (state_q == StSwitch)) ? 2'b11 : 2'b00;
  assign dcache_flush_o    = flush_q;
  assign fail_cnt_o        = fail_cnt_q;
  assign fail_irq_o        = irq_q;

endmodule

// File: tb/tb_hmr_mode_ctrl.sv
// Scoreboard bench for hmr_mode_ctrl: expected done/err events are queued, a monitor pops them.
module tb_hmr_mode_ctrl;

  localparam int unsigned Tmo = 16;
  localparam int unsigned Fw  = 8;

  logic          clk, rst_n;
  logic          req_valid, req_dmr, req_ready, done, err, dmr_active;
  logic [1:0]    halt, halted, flush, flush_ack, wbuf_empty;
  logic          failure, cnt_clr, irq;
  logic [Fw-1:0] fail_cnt;

  typedef struct packed {
    logic is_err;
    logic mode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hmr_mode_ctrl #(
    .TimeoutCycles(Tmo),
    .FailCntWidth (Fw),
    .ResetDmr     (1'b0)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .mode_req_valid_i      (req_valid),
    .mode_req_dmr_i        (req_dmr),
    .mode_req_ready_o      (req_ready),
    .mode_done_o           (done),
    .mode_err_o            (err),
    .dmr_mode_active_o     (dmr_active),
    .core_halt_o           (halt),
    .core_halted_i         (halted),
    .dcache_flush_o        (flush),
    .dcache_flush_ack_i    (flush_ack),
    .dcache_wbuffer_empty_i(wbuf_empty),
    .dmr_failure_i         (failure),
    .fail_cnt_clr_i        (cnt_clr),
    .fail_cnt_o            (fail_cnt),
    .fail_irq_o            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b mode=%0b, expected no event",
                 done, err, dmr_active);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (done !== !e.is_err || err !== e.is_err || dmr_active !== e.mode) begin
          errors++;
          $display("FAIL event: done=%0b err=%0b mode=%0b expected done=%0b err=%0b mode=%0b",
                   done, err, dmr_active, !e.is_err, e.is_err, e.mode);
        end
      end
    end
  end

  // Full transition with a cooperative environment; bounded wait for completion.
  task automatic do_switch(input logic target);
    halted     = 2'b11;
    flush_ack  = 2'b11;
    wbuf_empty = 2'b11;
    req_valid  = 1'b1;
    req_dmr    = target;
    exp_q.push_back('{is_err: 1'b0, mode: target});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 60 && !(done || err); i++) tick();
    chk("switch_completed", {31'b0, done}, 1);
    tick();
    halted    = 2'b00;
    flush_ack = 2'b00;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_dmr    = 1'b0;
    halted     = 2'b00;
    flush_ack  = 2'b00;
    wbuf_empty = 2'b11;
    failure    = 1'b0;
    cnt_clr    = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_mode", {31'b0, dmr_active}, 0);
    chk("rst_halt", {30'b0, halt}, 0);
    chk("rst_flush", {30'b0, flush}, 0);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_cnt", {24'b0, fail_cnt}, 0);
    chk("rst_irq", {31'b0, irq}, 0);

    // Independent -> DMR, halt ack after 2 cycles, flush acks after 3
    req_valid = 1'b1;
    req_dmr   = 1'b1;
    exp_q.push_back('{is_err: 1'b0, mode: 1'b1});
    tick();
    req_valid = 1'b0;
    chk("t1_halt", {30'b0, halt}, 3);
    chk("t1_ready_busy", {31'b0, req_ready}, 0);
    tick();
    tick();
    halted = 2'b11;
    tick();
    chk("t1_flush_entry", {30'b0, flush}, 3);
    tick();
    tick();
    chk("t1_flush_held", {30'b0, flush}, 3);
    flush_ack = 2'b11;
    tick();
    flush_ack = 2'b00;
    chk("t1_flush_cleared", {30'b0, flush}, 0);
    tick();
    tick();
    chk("t1_mode_dmr", {31'b0, dmr_active}, 1);
    chk("t1_halt_released", {30'b0, halt}, 0);
    tick();
    halted = 2'b00;

    // DMR -> independent: only cache0 flushed, cache1 ack/wbuffer ignored
    halted     = 2'b11;
    wbuf_empty = 2'b01;
    req_valid  = 1'b1;
    req_dmr    = 1'b0;
    exp_q.push_back('{is_err: 1'b0, mode: 1'b0});
    tick();
    req_valid = 1'b0;
    tick();
    chk("t2_flush_cache0", {30'b0, flush}, 1);
    flush_ack = 2'b01;
    tick();
    flush_ack = 2'b00;
    tick();
    tick();
    chk("t2_mode_indep", {31'b0, dmr_active}, 0);
    tick();
    wbuf_empty = 2'b11;

    // Halt timeout: core1 never acknowledges
    halted    = 2'b01;
    req_valid = 1'b1;
    req_dmr   = 1'b1;
    exp_q.push_back('{is_err: 1'b1, mode: 1'b0});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t3_no_err_early", {31'b0, err}, 0);
    chk("t3_still_halting", {30'b0, halt}, 3);
    tick();
    chk("t3_err_pulse", {31'b0, err}, 1);
    chk("t3_no_done", {31'b0, done}, 0);
    chk("t3_mode_kept", {31'b0, dmr_active}, 0);
    chk("t3_halt_released", {30'b0, halt}, 0);
    tick();
    tick();
    halted = 2'b00;

    // Same-mode request
    req_valid = 1'b1;
    req_dmr   = 1'b0;
    exp_q.push_back('{is_err: 1'b0, mode: 1'b0});
    tick();
    req_valid = 1'b0;
    chk("t5_done", {31'b0, done}, 1);
    chk("t5_no_halt", {30'b0, halt}, 0);
    chk("t5_ready", {31'b0, req_ready}, 1);
    tick();
    chk("t5_done_single", {31'b0, done}, 0);

    // Failures in independent mode are ignored
    failure = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    failure = 1'b0;
    chk("t4_indep_ignored", {24'b0, fail_cnt}, 0);
    chk("t4_indep_no_irq", {31'b0, irq}, 0);

    do_switch(1'b1);

`ifdef HMR_MODE_CTRL_AUTO_FALLBACK_EN
    // One failure in DMR+IDLE falls back to independent mode unrequested
    exp_q.push_back('{is_err: 1'b0, mode: 1'b0});
    halted     = 2'b11;
    flush_ack  = 2'b11;
    failure    = 1'b1;
    tick();
    failure = 1'b0;
    for (int i = 0; i < 60 && !done; i++) tick();
    chk("fb_done", {31'b0, done}, 1);
    tick();
    chk("fb_mode_indep", {31'b0, dmr_active}, 0);
    chk("fb_cnt", {24'b0, fail_cnt}, 1);
    halted    = 2'b00;
    flush_ack = 2'b00;
    do_switch(1'b1);
`else
    // Saturation and clear-with-failure
    failure = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("t4_saturated", {24'b0, fail_cnt}, 255);
    chk("t4_irq", {31'b0, irq}, 1);
    chk("t4_mode_kept", {31'b0, dmr_active}, 1);
    cnt_clr = 1'b1;
    tick();
    chk("t4_clr_with_fail_cnt", {24'b0, fail_cnt}, 1);
    chk("t4_clr_with_fail_irq", {31'b0, irq}, 1);
    failure = 1'b0;
    tick();
    cnt_clr = 1'b0;
    chk("t4_clr_cnt", {24'b0, fail_cnt}, 0);
    chk("t4_clr_irq", {31'b0, irq}, 0);
`endif

    // Reset while flushing during DMR -> independent
    halted    = 2'b11;
    flush_ack = 2'b00;
    req_valid = 1'b1;
    req_dmr   = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t6_in_flush", {30'b0, flush}, 1);
    chk("t6_mode_before", {31'b0, dmr_active}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_mode", {31'b0, dmr_active}, 0);
    chk("t6_rst_halt", {30'b0, halt}, 0);
    chk("t6_rst_flush", {30'b0, flush}, 0);
    halted = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
